// File: rtl/gate_resp_checker.sv
`default_nettype none
// ============================================================================
// Module      : gate_resp_checker
// Description : Response checker for a combinational gate under test. Accepts
//               (vector, observed output) pairs over valid/ready, compares
//               them against a truth-table parameter, tracks vector coverage,
//               counts failures, latches the first failing vector and reports
//               done/pass once every input combination has been seen.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_resp_checker #(
  parameter int                 N_IN  = 2,
  parameter logic [2**N_IN-1:0] TRUTH = 4'b1000,
  parameter int                 ERR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_IN-1:0]      in_vec,
  input  logic                 in_f,
  output logic                 mismatch,
  output logic [ERR_W-1:0]     err_cnt,
  output logic [2**N_IN-1:0]   covered,
  output logic [N_IN-1:0]      first_fail_vec,
  output logic                 first_fail_valid,
  output logic                 done,
  output logic                 pass
);

  localparam int                   c_NUM_VEC = 2**N_IN;
  localparam logic [c_NUM_VEC-1:0] c_VEC_ONE = c_NUM_VEC'(1);
  localparam logic [ERR_W-1:0]     c_ERR_MAX = '1;
  localparam logic [ERR_W-1:0]     c_ERR_ONE = ERR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic                   r_mismatch;
  logic [ERR_W-1:0]       r_err_cnt;
  logic [c_NUM_VEC-1:0]   r_covered;
  logic [N_IN-1:0]        r_ff_vec;
  logic                   r_ff_valid;

  logic                   w_accept;
  logic                   w_exp;
  logic                   w_fail;
  logic [c_NUM_VEC-1:0]   w_onehot;
  logic                   w_cov_full;

  // Handshake and comparison terms; start always wins over a coincident sample
  assign in_ready   = (r_state == ST_CHECK) && !start;
  assign w_accept   = in_valid && in_ready;
  assign w_exp      = TRUTH[in_vec];
  assign w_fail     = (in_f != w_exp);
  assign w_onehot   = c_VEC_ONE << in_vec;
  assign w_cov_full = &(r_covered | w_onehot);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: start (re)enters CHECK from anywhere, full coverage ends it
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (start)                       w_state_nxt = ST_CHECK;
        else if (w_accept && w_cov_full) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (start) w_state_nxt = ST_CHECK;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Statistics: cleared by start, updated on accept, frozen otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mismatch <= 1'b0;
      r_err_cnt  <= '0;
      r_covered  <= '0;
      r_ff_vec   <= '0;
      r_ff_valid <= 1'b0;
    end else if (start) begin
      r_mismatch <= 1'b0;
      r_err_cnt  <= '0;
      r_covered  <= '0;
      r_ff_vec   <= '0;
      r_ff_valid <= 1'b0;
    end else if (w_accept) begin
      r_covered  <= r_covered | w_onehot;
      r_mismatch <= w_fail;
      if (w_fail) begin
        // Saturate rather than wrap so a long failing run never reads as clean
        if (r_err_cnt != c_ERR_MAX) r_err_cnt <= r_err_cnt + c_ERR_ONE;
        if (!r_ff_valid) begin
          r_ff_vec   <= in_vec;
          r_ff_valid <= 1'b1;
        end
      end
    end else begin
      r_mismatch <= 1'b0;
    end
  end

  assign mismatch         = r_mismatch;
  assign err_cnt          = r_err_cnt;
  assign covered          = r_covered;
  assign first_fail_vec   = r_ff_vec;
  assign first_fail_valid = r_ff_valid;
  assign done             = (r_state == ST_DONE);
  assign pass             = done && (r_err_cnt == '0);

endmodule
`default_nettype wire

// File: tb/tb_gate_resp_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_resp_checker
// Description : Self-checking bench for gate_resp_checker. A default instance
//               (and2 truth table, 8-bit counter) and a 2-bit-counter instance
//               share one stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_resp_checker;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic [1:0] in_vec;
  logic       in_f;

  logic       in_ready,  mismatch,  ffok,   done,   pass;
  logic [7:0] err_cnt;
  logic [3:0] covered;
  logic [1:0] ffvec;

  logic       rdy_s, mm_s, ffok_s, done_s, pass_s;
  logic [1:0] err_s;
  logic [3:0] cov_s;
  logic [1:0] ffvec_s;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       restart;
    logic [1:0] vec;
    logic       f;
    logic       mm;
    logic [7:0] err;
    logic [3:0] cov;
    logic       dn;
  } row_t;

  row_t sb_q[$];

  gate_resp_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_vec(in_vec), .in_f(in_f), .mismatch(mismatch),
    .err_cnt(err_cnt), .covered(covered), .first_fail_vec(ffvec),
    .first_fail_valid(ffok), .done(done), .pass(pass)
  );

  gate_resp_checker #(.N_IN(2), .TRUTH(4'b1000), .ERR_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(rdy_s), .in_vec(in_vec), .in_f(in_f), .mismatch(mm_s),
    .err_cnt(err_s), .covered(cov_s), .first_fail_vec(ffvec_s),
    .first_fail_valid(ffok_s), .done(done_s), .pass(pass_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare both instances against one expected row; the 2-bit counter clamps at 3
  task automatic compare_row(input string tag, input row_t r);
    logic [7:0] sat;
    sat = (r.err > 8'd3) ? 8'd3 : r.err;
    check({tag, " mismatch"}, {31'd0, mismatch}, {31'd0, r.mm});
    check({tag, " err_cnt"},  {24'd0, err_cnt},  {24'd0, r.err});
    check({tag, " covered"},  {28'd0, covered},  {28'd0, r.cov});
    check({tag, " done"},     {31'd0, done},     {31'd0, r.dn});
    check({tag, " pass"},     {31'd0, pass},     {31'd0, r.dn && (r.err == 8'd0)});
    check({tag, " sat err"},  {30'd0, err_s},    {24'd0, sat});
    check({tag, " sat pass"}, {31'd0, pass_s},   {31'd0, r.dn && (r.err == 8'd0)});
  endtask

  // Drive one sample (called just after a negedge); result checked at next negedge
  task automatic send(input string tag, input logic [1:0] v, input logic f, input logic mm,
                      input logic [7:0] err, input logic [3:0] cov, input logic dn);
    row_t r;
    r.restart = 1'b0; r.vec = v; r.f = f; r.mm = mm; r.err = err; r.cov = cov; r.dn = dn;
    in_valid = 1'b1; in_vec = v; in_f = f;
    #1;
    check({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    sb_q.push_back(r);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s scoreboard: got empty queue expected one entry", tag);
    end else begin
      r = sb_q.pop_front();
      compare_row(tag, r);
    end
  endtask

  // Idle cycles with in_valid low: statistics hold, mismatch stays low
  task automatic idle(input string tag, input int n, input logic [3:0] cov);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("%s idle%0d mismatch", tag, i), {31'd0, mismatch}, 32'd0);
      check($sformatf("%s idle%0d covered", tag, i), {28'd0, covered}, {28'd0, cov});
    end
  endtask

  task automatic pulse_start(input string tag);
    start = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    #1;
    check({tag, " start in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, " start err_cnt"},  {24'd0, err_cnt},  32'd0);
    check({tag, " start covered"},  {28'd0, covered},  32'd0);
    check({tag, " start ffok"},     {31'd0, ffok},     32'd0);
    check({tag, " start mismatch"}, {31'd0, mismatch}, 32'd0);
    check({tag, " start done"},     {31'd0, done},     32'd0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, " in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, " mismatch"}, {31'd0, mismatch}, 32'd0);
    check({tag, " err_cnt"},  {24'd0, err_cnt},  32'd0);
    check({tag, " covered"},  {28'd0, covered},  32'd0);
    check({tag, " ffvec"},    {30'd0, ffvec},    32'd0);
    check({tag, " ffok"},     {31'd0, ffok},     32'd0);
    check({tag, " done"},     {31'd0, done},     32'd0);
    check({tag, " pass"},     {31'd0, pass},     32'd0);
  endtask

  row_t tbl[8];

  initial begin
    // Sweep with correct and2 outputs, then the same sweep with vector 2 wrong
    tbl[0] = '{1'b1, 2'd0, 1'b0, 1'b0, 8'd0, 4'b0001, 1'b0};
    tbl[1] = '{1'b0, 2'd1, 1'b0, 1'b0, 8'd0, 4'b0011, 1'b0};
    tbl[2] = '{1'b0, 2'd2, 1'b0, 1'b0, 8'd0, 4'b0111, 1'b0};
    tbl[3] = '{1'b0, 2'd3, 1'b1, 1'b0, 8'd0, 4'b1111, 1'b1};
    tbl[4] = '{1'b1, 2'd0, 1'b0, 1'b0, 8'd0, 4'b0001, 1'b0};
    tbl[5] = '{1'b0, 2'd1, 1'b0, 1'b0, 8'd0, 4'b0011, 1'b0};
    tbl[6] = '{1'b0, 2'd2, 1'b1, 1'b1, 8'd1, 4'b0111, 1'b0};
    tbl[7] = '{1'b0, 2'd3, 1'b1, 1'b0, 8'd1, 4'b1111, 1'b1};

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_vec = 2'd0; in_f = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    in_valid = 1'b1; in_vec = 2'd3; in_f = 1'b1;
    @(negedge clk);
    check_reset("idle no start");

    // Table-driven sweeps
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].restart) pulse_start($sformatf("row%0d", i));
      send($sformatf("row%0d", i), tbl[i].vec, tbl[i].f, tbl[i].mm, tbl[i].err, tbl[i].cov, tbl[i].dn);
      if (i == 3) check("sweep1 ffok", {31'd0, ffok}, 32'd0);
      if (i == 7) begin
        check("sweep2 ffvec", {30'd0, ffvec}, 32'd2);
        check("sweep2 ffok",  {31'd0, ffok},  32'd1);
      end
    end
    // DONE ignores further samples
    idle("done hold", 1, 4'b1111);
    in_valid = 1'b1; in_vec = 2'd0; in_f = 1'b1;
    #1 check("done in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("done frozen err", {24'd0, err_cnt}, 32'd1);
    check("done frozen done", {31'd0, done}, 32'd1);

    // Out-of-order with duplicate and gaps
    pulse_start("dup");
    send("dup v3a", 2'd3, 1'b1, 1'b0, 8'd0, 4'b1000, 1'b0);
    idle("dup g1", 2, 4'b1000);
    send("dup v3b", 2'd3, 1'b1, 1'b0, 8'd0, 4'b1000, 1'b0);
    idle("dup g2", 2, 4'b1000);
    send("dup v0", 2'd0, 1'b0, 1'b0, 8'd0, 4'b1001, 1'b0);
    idle("dup g3", 2, 4'b1001);
    send("dup v1", 2'd1, 1'b0, 1'b0, 8'd0, 4'b1011, 1'b0);
    idle("dup g4", 2, 4'b1011);
    send("dup v2", 2'd2, 1'b0, 1'b0, 8'd0, 4'b1111, 1'b1);

    // Saturation: six failures on vector 0
    pulse_start("sat");
    for (int k = 1; k <= 6; k++)
      send($sformatf("sat f%0d", k), 2'd0, 1'b1, 1'b1, 8'(k), 4'b0001, 1'b0);
    send("sat v1", 2'd1, 1'b0, 1'b0, 8'd6, 4'b0011, 1'b0);
    send("sat v2", 2'd2, 1'b0, 1'b0, 8'd6, 4'b0111, 1'b0);
    send("sat v3", 2'd3, 1'b1, 1'b0, 8'd6, 4'b1111, 1'b1);
    check("sat ffvec", {30'd0, ffvec_s}, 32'd0);
    check("sat ffok",  {31'd0, ffok_s},  32'd1);

    // Start coinciding with a valid sample mid-sweep
    pulse_start("sv");
    send("sv v0", 2'd0, 1'b0, 1'b0, 8'd0, 4'b0001, 1'b0);
    send("sv v1", 2'd1, 1'b0, 1'b0, 8'd0, 4'b0011, 1'b0);
    start = 1'b1; in_valid = 1'b1; in_vec = 2'd2; in_f = 1'b1;
    #1 check("sv in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    #1;
    check("sv covered",  {28'd0, covered},  32'd0);
    check("sv err_cnt",  {24'd0, err_cnt},  32'd0);
    check("sv mismatch", {31'd0, mismatch}, 32'd0);
    check("sv in_ready2", {31'd0, in_ready}, 32'd1);

    // Asynchronous reset mid-sweep, right after a failing accept
    send("ar v0", 2'd0, 1'b1, 1'b1, 8'd1, 4'b0001, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_reset("async mid");
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; in_vec = 2'd2; in_f = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_reset($sformatf("post reset %0d", i));
    end

    // Asynchronous reset while in DONE
    pulse_start("ad");
    send("ad v0", 2'd0, 1'b0, 1'b0, 8'd0, 4'b0001, 1'b0);
    send("ad v1", 2'd1, 1'b0, 1'b0, 8'd0, 4'b0011, 1'b0);
    send("ad v2", 2'd2, 1'b0, 1'b0, 8'd0, 4'b0111, 1'b0);
    send("ad v3", 2'd3, 1'b1, 1'b0, 8'd0, 4'b1111, 1'b1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset("async done");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset("after done reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gate_resp_checker.md
Name: gate_resp_checker

Overview:
- Response-checking end of the gate-level stimulus/response flow.
- A stimulus generator sweeps input vectors into a combinational gate DUT. This block samples each (vector, DUT output) pair over a valid/ready handshake.
- Each pair is compared against a parameterised truth table. The block tracks vector coverage, counts mismatches, latches the first failing vector, and raises done/pass once every input combination has been seen.
- It replaces $display-based inspection with a synthesizable self-check usable in both simulation and on-chip BIST.

Parameters:
- N_IN, 2, number of DUT inputs; vector space is 2**N_IN.
- TRUTH, 4'b1000, expected DUT output indexed by input vector (bit k = f for in_vec==k); default is and2. Width is 2**N_IN.
- ERR_W, 8, width of the mismatch counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; clears statistics and (re)enters CHECK.
- in_valid  input  1  sample pair present.
- in_ready  output  1  checker accepts a sample this cycle.
- in_vec  input  N_IN  applied DUT input vector (MSB = first DUT input).
- in_f  input  1  observed DUT output for in_vec.
- mismatch  output  1  registered one-cycle pulse, asserted the cycle after a failing sample is accepted.
- err_cnt  output  ERR_W  saturating count of failing samples.
- covered  output  2**N_IN  bit k set once vector k has been accepted.
- first_fail_vec  output  N_IN  in_vec of the first failing sample since start.
- first_fail_valid  output  1  first_fail_vec holds a captured value.
- done  output  1  high in DONE state.
- pass  output  1  done && err_cnt==0.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=0, mismatch=0, err_cnt=0, covered=0, first_fail_vec=0, first_fail_valid=0, done=0, pass=0. Reset asserted mid-sweep aborts immediately to these values.
- FSM states: IDLE, CHECK, DONE.
  - IDLE: waits for start.
  - CHECK: accepts samples.
  - DONE: holds results.
- Transitions:
  - IDLE --start--> CHECK.
  - CHECK --(accept that completes coverage)--> DONE.
  - CHECK --start--> CHECK (restart).
  - DONE --start--> CHECK.
- Clear on start: any start clears err_cnt, covered, first_fail_valid, first_fail_vec and mismatch on the same edge it changes state.
- in_ready is combinational: (state==CHECK) && !start. A sample coinciding with start is therefore never accepted (start wins).
- Accept condition: in_valid && in_ready at a rising edge.
- Expected output: exp = TRUTH[in_vec]; fail = (in_f != exp).
- On every accept:
  - covered[in_vec] <= 1.
  - If fail:
    - mismatch <= 1.
    - err_cnt increments, saturating at 2**ERR_W-1.
    - If !first_fail_valid: capture first_fail_vec=in_vec and set first_fail_valid=1.
  - Otherwise mismatch <= 0.
- mismatch is 0 in any cycle not following a failing accept.
- Duplicate vectors: rechecked and counted; coverage unchanged. Out-of-order vectors are allowed.
- Completion: if (covered | onehot(in_vec)) is all ones at the accept edge, next state is DONE.
  - done=1 and pass is valid starting the cycle after the final accept.
  - Latency from final accept to done is 1 cycle.
- DONE: in_ready=0 and all statistics frozen; in_valid is ignored.
- Handshake: the upstream holds in_vec/in_f stable while in_valid && !in_ready. The checker does not depend on in_valid being deasserted between samples and accepts back-to-back, one per cycle.
- err_cnt uses unsigned arithmetic. Saturation holds the value without wrap; the pass result stays 0 once any failure has occurred.

Test Plan:
1. Reset, start, then vectors 0,1,2,3 with f=0,0,0,1 back-to-back → mismatch never set, covered=4'b1111, done=1 one cycle after vector 3, err_cnt=0, pass=1.
2. Same sweep with f=1 on vector 2 → mismatch pulses one cycle after vector 2, err_cnt=1, first_fail_vec=2'b10, first_fail_valid=1, done=1, pass=0.
3. Vectors 3,3,0,1,2 with correct f; in_valid deasserted for 2 cycles between samples → done only after vector 2; covered stays 4'b1000 through the duplicate; err_cnt=0, pass=1.
4. ERR_W=2, 6 failing samples on vector 0 then vectors 1,2,3 correct → err_cnt saturates at 3, first_fail_vec=0, pass=0.
5. Start pulse asserted together with in_valid mid-sweep (after 2 accepts) → in_ready=0 that cycle, sample not counted, covered=0 and err_cnt=0 next cycle, state CHECK.
6. Assert rst_n=0 asynchronously mid-sweep and again while in DONE → all outputs return to reset values without a clock edge; no sample is accepted until the next start.
